// File: rtl/seg_txt_serializer.sv
// Bit-serial transmitter for one 64-bit segment-text frame to cascaded shift registers.
// Frames shift out MSB first on a divided clock; a done pulse and output-enable close each frame.
module seg_txt_serializer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seg_txt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             seg_clk_o,
  output logic             seg_sout_o,
  output logic             seg_pen_o,
  output logic             seg_clrn_o
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StShiftLo = 2'd1;
  localparam logic [1:0] StShiftHi = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BitW-1:0]  sout_sel;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic seg_clk_q, seg_clk_d;
  logic seg_sout_q, seg_sout_d;
  logic seg_pen_q, seg_pen_d;
  logic seg_clrn_q;

  // Done doubles as an idle cycle so a held start gives gap-free framing.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          shadow_d = seg_txt_i;
          div_d    = '0;
          bit_d    = '0;
          state_d  = StShiftLo;
        end else begin
          state_d  = StIdle;
        end
      end
      StShiftLo: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = StShiftHi;
        end else begin
          div_d   = div_q + 1'b1;
        end
      end
      StShiftHi: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == BitLast) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StShiftLo;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so they land registered in the same cycle as the state.
  always_comb begin
    sout_sel   = BitLast - bit_d;
    busy_d     = (state_d == StShiftLo) || (state_d == StShiftHi);
    done_d     = (state_d == StDone);
    seg_clk_d  = (state_d == StShiftHi);
    seg_sout_d = busy_d ? shadow_d[sout_sel] : 1'b0;
    if (state_d == StDone) begin
      seg_pen_d = 1'b1;
    end else if (state_d == StIdle) begin
      seg_pen_d = seg_pen_q;
    end else begin
      seg_pen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      shadow_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_clk_q  <= 1'b0;
      seg_sout_q <= 1'b0;
      seg_pen_q  <= 1'b0;
      seg_clrn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      seg_clk_q  <= seg_clk_d;
      seg_sout_q <= seg_sout_d;
      seg_pen_q  <= seg_pen_d;
      seg_clrn_q <= 1'b1;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign seg_clk_o  = seg_clk_q;
  assign seg_sout_o = seg_sout_q;
  assign seg_pen_o  = seg_pen_q;
  assign seg_clrn_o = seg_clrn_q;

endmodule

// File: tb/tb_seg_txt_serializer.sv
// Directed bench for seg_txt_serializer: three instances with DIV = 1, 2, 3 and WIDTH = 64.
// Each instance has a shift-register model clocked on seg_clk rising edges.
module tb_seg_txt_serializer;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  start;
  logic [63:0] txt [3];
  logic [2:0]  busy, done, sclk, sout, pen, clrn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seg_txt_serializer #(.WIDTH(64), .DIV(g + 1)) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n[g]),
      .start_i   (start[g]),
      .seg_txt_i (txt[g]),
      .busy_o    (busy[g]),
      .done_o    (done[g]),
      .seg_clk_o (sclk[g]),
      .seg_sout_o(sout[g]),
      .seg_pen_o (pen[g]),
      .seg_clrn_o(clrn[g])
    );

    logic [63:0] sr = '0;
    int          rises = 0;
    logic        clk_prev = 1'b0;

    // Display-side model: shift in seg_sout on each seg_clk rising edge.
    always @(negedge clk) begin
      clk_prev <= sclk[g];
      if (sclk[g] === 1'b1 && clk_prev !== 1'b1) begin
        sr    <= {sr[62:0], sout[g]};
        rises <= rises + 1;
      end
    end
  end

  function automatic logic [63:0] sr_of(input int g);
    case (g)
      0:       return g_dut[0].sr;
      1:       return g_dut[1].sr;
      default: return g_dut[2].sr;
    endcase
  endfunction

  function automatic int rises_of(input int g);
    case (g)
      0:       return g_dut[0].rises;
      1:       return g_dut[1].rises;
      default: return g_dut[2].rises;
    endcase
  endfunction

  // Packed view {busy, done, seg_clk, seg_sout, seg_pen, seg_clrn}.
  function automatic logic [5:0] outs(input int g);
    return {busy[g], done[g], sclk[g], sout[g], pen[g], clrn[g]};
  endfunction

  // Expected outputs in cycle T+i of a frame accepted at cycle T.
  function automatic logic [5:0] exp_out(input int i, input int d, input logic [63:0] data);
    int k;
    int p;
    if (i <= 128 * d) begin
      k = (i - 1) / (2 * d);
      p = (i - 1) % (2 * d);
      return {1'b1, 1'b0, (p >= d), data[63 - k], 1'b0, 1'b1};
    end
    return 6'b010011;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int g, input int d, input logic [63:0] data, input bit disturb,
                           input string tag);
    int r0;
    r0       = rises_of(g);
    txt[g]   = data;
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    for (int i = 1; i <= 128 * d + 1; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), 64'(outs(g)), 64'(exp_out(i, d, data)));
      if (disturb) begin
        txt[g]   = {$urandom, $urandom};
        start[g] = (i == 40 || i == 100);
      end
      tick();
    end
    chk({tag, "_idle"}, 64'(outs(g)), 64'(6'b000011));
    chk({tag, "_stream"}, sr_of(g), data);
    chk({tag, "_edges"}, 64'(rises_of(g) - r0), 64'd64);
  endtask

  initial begin
    logic [63:0] bb [3];
    logic [63:0] data;
    int n;
    bb[0] = 64'h1357_9BDF_2468_ACE0;
    bb[1] = 64'hFFFF_0000_FFFF_0001;
    bb[2] = 64'h8421_1248_C3C3_3C3C;

    rst_n = '0;
    start = '0;
    for (int g = 0; g < 3; g++) txt[g] = '0;

    // Reset values
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int g = 0; g < 3; g++) chk($sformatf("rst_c%0d_g%0d", c, g), 64'(outs(g)), 64'd0);
    end
    rst_n = '1;
    tick();
    for (int g = 0; g < 3; g++) chk($sformatf("rel_g%0d", g), 64'(outs(g)), 64'(6'b000001));

    // Single frame, DIV=2
    run_frame(1, 2, 64'h8000_0000_0000_0001, 1'b0, "single");

    // Data isolation with mid-frame start pulses
    run_frame(1, 2, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, "isolate");
    repeat (5) tick();
    chk("isolate_no_restart", 64'(outs(1)), 64'(6'b000011));

    // Reset one cycle after bit 20's rising edge
    txt[1]   = 64'h0F1E_2D3C_4B5A_6978;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int i = 1; i <= 83; i++) begin
      chk($sformatf("abort_cyc%0d", i), 64'(outs(1)), 64'(exp_out(i, 2, 64'h0F1E_2D3C_4B5A_6978)));
      tick();
    end
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    chk("abort_reset", 64'(outs(1)), 64'd0);
    tick();
    chk("abort_release", 64'(outs(1)), 64'(6'b000001));
    run_frame(1, 2, 64'hDEAD_BEEF_0123_4567, 1'b0, "after_abort");

    // Back-to-back with start held, DIV=1
    txt[0]   = bb[0];
    start[0] = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int i = 1; i <= 129; i++) begin
        chk($sformatf("b2b_f%0d_cyc%0d", f, i), 64'(outs(0)), 64'(exp_out(i, 1, bb[f])));
        if (i == 129) begin
          chk($sformatf("b2b_f%0d_stream", f), sr_of(0), bb[f]);
          if (f < 2) txt[0] = bb[f + 1];
          else start[0] = 1'b0;
        end
        tick();
      end
    end
    chk("b2b_idle", 64'(outs(0)), 64'(6'b000011));

    // Random frames against the display model, DIV=3
    for (int f = 0; f < 100; f++) begin
      data     = {$urandom, $urandom};
      txt[2]   = data;
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      txt[2]   = {$urandom, $urandom};
      n = 1;
      while (done[2] !== 1'b1 && n < 400) begin
        tick();
        n++;
      end
      chk($sformatf("sb_f%0d_latency", f), 64'(n), 64'd385);
      chk($sformatf("sb_f%0d_data", f), sr_of(2), data);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_txt_serializer.md
# seg_txt_serializer

Transmit side of the 8-digit segment display path: takes one 64-bit segment-text frame (8 digits × 8 segment bits, as produced by the hex-to-segment encoder), latches it, and shifts it out bit-serially with a divided shift clock to the board's cascaded serial-in shift registers. It sits between the segment encoder and the display pins. It owns shift timing, the output-enable (blanking) signal and a frame-complete handshake.

## Interface
- WIDTH, 64, frame length in bits; must be ≥ 2.
- DIV, 4, system clocks per seg_clk half-period; must be ≥ 1.

- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- seg_txt  in  WIDTH  frame data; captured on the accepted start cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame completion.
- seg_clk  out  1  shift clock to display; the display samples on the rising edge.
- seg_sout  out  1  serial data.
- seg_pen  out  1  display output enable; 0 blanks the display.
- seg_clrn  out  1  display register clear, active-low.

## Operation
- Reset (rst_n=0 at a clk edge) sets state IDLE, busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, and clears all counters and the shadow register.
- seg_clrn rises to 1 on the first clock with rst_n=1 and stays 1 until the next reset.
- **IDLE**
  - seg_clk=0 and seg_sout=0.
  - seg_pen holds its last value: 0 after reset, 1 after any completed frame.
  - start=1 captures seg_txt into the shadow register and moves to SHIFT_LO.
- **SHIFT_LO** (DIV cycles)
  - busy=1, seg_pen=0, seg_clk=0.
  - seg_sout = shadow[WIDTH-1-k] for current bit index k. Bits go MSB first: bit WIDTH-1 first, bit 0 last.
  - Then moves to SHIFT_HI.
- **SHIFT_HI** (DIV cycles)
  - seg_clk=1 and seg_sout is held stable.
  - If k < WIDTH-1: k increments and the state returns to SHIFT_LO.
  - Otherwise the state moves to DONE.
- **DONE** (1 cycle)
  - busy=0, done=1, seg_clk=0, seg_sout=0, seg_pen=1.
  - This cycle counts as IDLE for start sampling: start=1 here captures a new frame and the next cycle is SHIFT_LO.
- start asserted while busy=1 is ignored. No queuing.
- Changes to seg_txt after capture have no effect on the frame in flight.
- Reset mid-frame aborts immediately. seg_pen stays 0 until a later frame completes.
- Counters:
  - The divider counter is clog2(DIV) bits (1 bit minimum) and wraps at DIV-1.
  - The bit index is clog2(WIDTH) bits and never exceeds WIDTH-1.
- All outputs are registered. No output is a combinational function of the inputs.

## Timing
- Start accepted at cycle T. Outputs change at T+1.
- Bit k: low phase covers cycles T+1+2kDIV … T+(2k+1)DIV; high phase covers T+(2k+1)DIV+1 … T+2(k+1)DIV.
- seg_clk rising edges land at T+(2k+1)DIV+1. seg_sout has been stable for DIV cycles before each rising edge and remains stable for DIV cycles after it.
- done=1 and seg_pen 0→1 occur at T+2·WIDTH·DIV+1.
- Start held high continuously gives a frame period of 2·WIDTH·DIV+1 cycles.
- With the defaults (WIDTH=64, DIV=4), a frame is 512 shift cycles plus 1 done cycle.

## Test plan
- **Reset values.** rst_n=0 for 3 cycles, then release → all outputs 0 during reset. seg_clrn=1 on the first cycle after release; all other outputs remain 0.
- **Single frame, DIV=2, WIDTH=64, seg_txt=64'h8000_0000_0000_0001, start at T.**
  - Exactly 64 seg_clk rising edges, first at T+3.
  - Bits sampled on rising edges: 1, 62 zeros, then 1.
  - done pulses only at T+257, coincident with seg_pen rising.
  - busy=1 from T+1 to T+256.
- **Data isolation.** Start with 64'hA5A5_5A5A_0F0F_F0F0, then change seg_txt every cycle and pulse start mid-frame → the sampled stream equals A5A5_5A5A_0F0F_F0F0 MSB first; no extra frame and no restart.
- **Back-to-back.** Hold start=1 with DIV=1 → frames start every 129 cycles. done pulses once per frame. seg_pen drops to 0 on the cycle after each done.
- **Reset mid-frame.** rst_n=0 for one cycle after bit 20's rising edge → next cycle: state IDLE, seg_pen=0, busy=0, no done. A following start sends a complete new frame.
- **Scoreboard (DIV=3).** Run 100 random frames through a 64-bit shift-register model clocked on seg_clk → the model contents equal the captured seg_txt at every done.
